// File: rtl/dcache_perf_monitor.sv
// Data-cache performance monitor: classifies dcache accesses as hits or misses,
// keeps saturating live counters and a snapshot bank read through a select mux.
module dcache_perf_monitor #(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned NUM_CNT = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               mem_read_i,
  input  logic               mem_write_i,
  input  logic               stall_i,
  input  logic               idle_i,
  input  logic               dirty_i,
  input  logic               enable_i,
  input  logic               clear_i,
  input  logic               snap_i,
  input  logic [2:0]         sel_i,
  output logic [CNT_W-1:0]   cnt_o,
  output logic [NUM_CNT-1:0] ovf_o
);

  localparam int unsigned IdxRdHit  = 0;
  localparam int unsigned IdxRdMiss = 1;
  localparam int unsigned IdxWrHit  = 2;
  localparam int unsigned IdxWrMiss = 3;
  localparam int unsigned IdxWb     = 4;
  localparam int unsigned IdxStall  = 5;
  localparam int unsigned IdxTotal  = 6;
  localparam int unsigned IdxAcc    = 7;

  typedef enum logic [0:0] {StRun, StMissWait} state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q    [NUM_CNT];
  logic [CNT_W-1:0]     cnt_d    [NUM_CNT];
  logic [CNT_W-1:0]     shadow_q [NUM_CNT];
  logic [CNT_W-1:0]     shadow_d [NUM_CNT];
  logic [NUM_CNT-1:0]   ovf_q, ovf_d;
  logic [NUM_CNT-1:0]   inc;
  logic                 access;

  assign access = mem_read_i | mem_write_i;

  always_comb begin
    inc     = '0;
    state_d = state_q;
    unique case (state_q)
      StRun: begin
        if (access && stall_i && idle_i) begin
          // A simultaneous read and write is classified as a write.
          inc[mem_write_i ? IdxWrMiss : IdxRdMiss] = 1'b1;
          inc[IdxAcc] = 1'b1;
          inc[IdxWb]  = dirty_i;
          state_d     = StMissWait;
        end else if (access && !stall_i) begin
          inc[mem_write_i ? IdxWrHit : IdxRdHit] = 1'b1;
          inc[IdxAcc] = 1'b1;
        end
      end
      StMissWait: begin
        // The unstalled cycle retires the missed access without counting a hit.
        if (!stall_i) state_d = StRun;
      end
      default: state_d = StRun;
    endcase
    inc[IdxStall] = stall_i;
    inc[IdxTotal] = 1'b1;
    if (!enable_i) inc = '0;

    ovf_d = ovf_q;
    for (int i = 0; i < NUM_CNT; i++) begin
      cnt_d[i]    = cnt_q[i];
      shadow_d[i] = snap_i ? cnt_q[i] : shadow_q[i];
      if (inc[i]) begin
        if (cnt_q[i] == {CNT_W{1'b1}}) ovf_d[i] = 1'b1;
        else                           cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end

    if (clear_i) begin
      for (int i = 0; i < NUM_CNT; i++) cnt_d[i] = '0;
      ovf_d   = '0;
      state_d = StRun;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StRun;
      ovf_q   <= '0;
      for (int i = 0; i < NUM_CNT; i++) begin
        cnt_q[i]    <= '0;
        shadow_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      ovf_q   <= ovf_d;
      for (int i = 0; i < NUM_CNT; i++) begin
        cnt_q[i]    <= cnt_d[i];
        shadow_q[i] <= shadow_d[i];
      end
    end
  end

  assign cnt_o = shadow_q[sel_i];
  assign ovf_o = ovf_q;

endmodule

// File: tb/tb_dcache_perf_monitor.sv
// Scoreboard bench for dcache_perf_monitor: two widths driven in parallel against an
// unbounded-count reference model; saturation and overflow derive from the true counts.
module tb_dcache_perf_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, rd, wr, stall, idle, dirty, en, clr, snap;
  logic [2:0] sel;
  logic [15:0] cnt16;
  logic [3:0]  cnt4;
  logic [7:0]  ovf16, ovf4;

  dcache_perf_monitor #(.CNT_W(16), .NUM_CNT(8)) dut (
    .clk_i(clk), .rst_i(rst), .mem_read_i(rd), .mem_write_i(wr), .stall_i(stall),
    .idle_i(idle), .dirty_i(dirty), .enable_i(en), .clear_i(clr), .snap_i(snap),
    .sel_i(sel), .cnt_o(cnt16), .ovf_o(ovf16)
  );

  dcache_perf_monitor #(.CNT_W(4), .NUM_CNT(8)) dut4 (
    .clk_i(clk), .rst_i(rst), .mem_read_i(rd), .mem_write_i(wr), .stall_i(stall),
    .idle_i(idle), .dirty_i(dirty), .enable_i(en), .clear_i(clr), .snap_i(snap),
    .sel_i(sel), .cnt_o(cnt4), .ovf_o(ovf4)
  );

  localparam longint unsigned Max16 = 65535;
  localparam longint unsigned Max4  = 15;

  typedef struct {
    int               sel;
    longint unsigned  e16;
    longint unsigned  e4;
    logic [7:0]       o16;
    logic [7:0]       o4;
  } item_t;

  item_t sb[$];
  logic  rd_valid = 1'b0;
  int    n_tests = 0;
  int    n_fail  = 0;

  // Reference state: true event counts (never saturated) and the snapshotted counts.
  longint unsigned m_cnt[8];
  longint unsigned m_shd[8];
  bit              m_miss;

  function automatic longint unsigned sat(longint unsigned v, longint unsigned m);
    return (v > m) ? m : v;
  endfunction

  function automatic logic [7:0] ovf_of(longint unsigned m);
    logic [7:0] o;
    for (int i = 0; i < 8; i++) o[i] = (m_cnt[i] > m);
    return o;
  endfunction

  task automatic check(input bit ok, input string name, input longint unsigned act,
                       input longint unsigned exp);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_cnt[i] = 0;
      m_shd[i] = 0;
    end
    m_miss = 0;
  endtask

  // Applies one clock edge worth of the counting rules to the reference model.
  task automatic model_step();
    longint unsigned ev[8];
    bit acc;
    for (int i = 0; i < 8; i++) ev[i] = 0;
    if (snap) for (int i = 0; i < 8; i++) m_shd[i] = m_cnt[i];
    if (clr) begin
      for (int i = 0; i < 8; i++) m_cnt[i] = 0;
      m_miss = 0;
      return;
    end
    acc = rd | wr;
    if (!m_miss) begin
      if (acc && stall && idle) begin
        if (wr) ev[3] = 1; else ev[1] = 1;
        ev[7] = 1;
        if (dirty) ev[4] = 1;
        m_miss = 1;
      end else if (acc && !stall) begin
        if (wr) ev[2] = 1; else ev[0] = 1;
        ev[7] = 1;
      end
    end else if (!stall) begin
      m_miss = 0;
    end
    if (stall) ev[5] = 1;
    ev[6] = 1;
    if (en) for (int i = 0; i < 8; i++) m_cnt[i] += ev[i];
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    rd = 0; wr = 0; stall = 0; idle = 1; dirty = 0; clr = 0; snap = 0;
  endtask

  task automatic do_clear();
    quiet();
    clr = 1;
    step();
    clr = 0;
  endtask

  // Sweeps all shadow selects with counting frozen, queueing each expected response.
  task automatic readout();
    logic  en_save;
    item_t it;
    en_save = en;
    quiet();
    en = 0;
    for (int s = 0; s < 8; s++) begin
      sel    = 3'(s);
      it.sel = s;
      it.e16 = sat(m_shd[s], Max16);
      it.e4  = sat(m_shd[s], Max4);
      it.o16 = ovf_of(Max16);
      it.o4  = ovf_of(Max4);
      sb.push_back(it);
      rd_valid = 1;
      step();
    end
    rd_valid = 0;
    en = en_save;
  endtask

  task automatic snap_read();
    quiet();
    snap = 1;
    step();
    snap = 0;
    readout();
  endtask

  task automatic do_reset();
    rst = 1;
    model_reset();
    #2;
    rst = 0;
  endtask

  always @(negedge clk) begin
    if (rd_valid) begin
      if (sb.size() == 0) begin
        check(1'b0, "sb_empty", 0, 1);
      end else begin
        item_t it;
        it = sb.pop_front();
        check(cnt16 == it.e16[15:0], $sformatf("cnt16[%0d]", it.sel), cnt16, it.e16);
        check(cnt4 == it.e4[3:0], $sformatf("cnt4[%0d]", it.sel), cnt4, it.e4);
        check(ovf16 == it.o16, "ovf16", ovf16, it.o16);
        check(ovf4 == it.o4, "ovf4", ovf4, it.o4);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    en = 1; sel = 0;
    quiet();
    rst = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    readout();

    // Read miss, three stall cycles, then retire.
    do_clear();
    rd = 1; stall = 1; idle = 1; step();
    idle = 0; step(); step();
    stall = 0; step();
    snap_read();

    // Dirty write miss followed by two write hits.
    do_clear();
    wr = 1; stall = 1; idle = 1; dirty = 1; step();
    stall = 0; dirty = 0; step();
    step(); step();
    snap_read();

    // Long run of read hits saturates the narrow instance.
    do_clear();
    rd = 1;
    repeat (20) step();
    snap_read();

    // Clear and snap together capture the pre-clear values.
    do_clear();
    rd = 1;
    repeat (5) step();
    quiet(); clr = 1; snap = 1; step();
    readout();
    rd = 1;
    repeat (3) step();
    snap_read();

    // Whole miss episode with counting disabled; re-enabled on the retire cycle.
    do_clear();
    en = 0; rd = 1; stall = 1; idle = 1; step();
    rd = 0; idle = 0; step();
    stall = 0; en = 1; step();
    snap_read();

    // Reset in the middle of a miss; next unstalled read is a hit.
    do_clear();
    rd = 1; stall = 1; idle = 1; step();
    rd = 0; step();
    do_reset();
    stall = 0; rd = 1; step();
    snap_read();

    // Randomized traffic with occasional clear, snap and reset.
    for (int blk = 0; blk < 60; blk++) begin
      for (int c = 0; c < 25; c++) begin
        rd    = ($urandom_range(0, 99) < 45);
        wr    = ($urandom_range(0, 99) < 30);
        idle  = ($urandom_range(0, 99) < 70);
        dirty = ($urandom_range(0, 99) < 50);
        en    = ($urandom_range(0, 99) < 90);
        clr   = ($urandom_range(0, 99) < 3);
        snap  = ($urandom_range(0, 99) < 10);
        stall = stall ? ($urandom_range(0, 99) < 60) : ($urandom_range(0, 99) < 25);
        if ($urandom_range(0, 499) == 0) do_reset();
        step();
      end
      en = 1;
      snap_read();
    end

    quiet();
    repeat (2) step();
    check(sb.size() == 0, "sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dcache_perf_monitor.md
DCACHE_PERF_MONITOR -- requirements
Module: dcache_perf_monitor

Interface
REQ-001 SHALL have parameter CNT_W, default 32: width of every event counter; legal range 4..64.
REQ-002 SHALL have parameter NUM_CNT, fixed at 8: number of counters; sets sel_i width to 3.
REQ-003 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port mem_read_i  input  1  pipeline-stage-1 read request to dcache.
REQ-006 SHALL have port mem_write_i  input  1  pipeline-stage-1 write request to dcache.
REQ-007 SHALL have port stall_i  input  1  dcache stall output.
REQ-008 SHALL have port idle_i  input  1  dcache controller FSM in its idle state.
REQ-009 SHALL have port dirty_i  input  1  addressed dcache line dirty, i.e. the miss needs a write-back.
REQ-010 SHALL have port enable_i  input  1  counting enable.
REQ-011 SHALL have port clear_i  input  1  synchronous clear of counters and overflow flags.
REQ-012 SHALL have port snap_i  input  1  copy live counters into shadow registers.
REQ-013 SHALL have port sel_i  input  3  shadow-counter read select.
REQ-014 SHALL have port cnt_o  output  CNT_W  shadow counter addressed by sel_i.
REQ-015 SHALL have port ovf_o  output  NUM_CNT  sticky saturation flag per live counter.

Function
REQ-016 SHALL index counters as: 0 read-hit, 1 read-miss, 2 write-hit, 3 write-miss, 4 write-back, 5 stall-cycles, 6 total-cycles, 7 accesses (hits+misses).
REQ-017 SHALL define access = mem_read_i | mem_write_i; when both are high, the access SHALL be classified as a write.
REQ-018 SHALL implement a 2-state FSM: RUN and MISS_WAIT.
REQ-019 In RUN, access & stall_i & idle_i SHALL count one miss (read or write) plus one access, SHALL also count one write-back if dirty_i, and SHALL go to MISS_WAIT.
REQ-020 In RUN, access & !stall_i SHALL count one hit (read or write) plus one access, and SHALL stay in RUN.
REQ-021 In RUN, stall_i & !idle_i SHALL count no access event and SHALL stay in RUN.
REQ-022 In MISS_WAIT, the FSM SHALL stay while stall_i=1; the first cycle with stall_i=0 retires the missed access, SHALL NOT count a hit, and SHALL return to RUN.
REQ-023 Stall-cycles SHALL increment every cycle with stall_i=1; total-cycles SHALL increment every cycle.
REQ-024 Counter updates SHALL occur only when enable_i=1; the FSM SHALL track episodes regardless of enable_i.
REQ-025 Each counter SHALL saturate at 2^CNT_W-1 without wrapping; an increment attempted at saturation SHALL set its ovf_o bit, and that bit SHALL stay set until clear or reset.
REQ-026 clear_i SHALL, on the next edge, zero all live counters and ovf_o and force the FSM to RUN; clear SHALL take priority over any same-cycle event.
REQ-027 snap_i SHALL load all 8 shadow registers from the live counter values present before that edge's update.
REQ-028 With snap_i and clear_i in the same cycle, the shadows SHALL capture the pre-clear values.
REQ-029 cnt_o SHALL be a combinational mux of shadow[sel_i], with zero additional latency from sel_i.
REQ-030 Latency: an event in cycle N SHALL be visible in cnt_o after a snap_i in cycle N+1 or later.

Reset
REQ-031 rst_i high SHALL asynchronously zero all live counters, shadow registers and ovf_o, and set the FSM to RUN; cnt_o SHALL read 0.
REQ-032 rst_i asserted mid-miss (in MISS_WAIT) SHALL abandon the episode; after release, the first non-stalled access SHALL count as a hit.

Verification
REQ-033 Read, stall 3 cycles (first cycle idle_i=1, dirty_i=0), then unstall; then snap_i -> read-miss=1, read-hit=0, stall-cycles=3, accesses=1, write-back=0.
REQ-034 Write miss with dirty_i=1, followed by 2 unstalled writes; then snap_i -> write-miss=1, write-back=1, write-hit=2, accesses=3.
REQ-035 CNT_W=4, 20 consecutive read hits -> read-hit=15, ovf_o[0]=1, ovf_o[1]=0.
REQ-036 clear_i and snap_i together after 5 hits -> shadow read-hit=5 and live counter=0; the next snap reads 0 plus new events.
REQ-037 enable_i=0 across an entire miss episode, re-enabled on the retiring cycle -> read-hit=0 and read-miss=0.
REQ-038 rst_i pulse in MISS_WAIT, then one unstalled read -> read-hit=1 and FSM in RUN.
